// File: rtl/riscv_pkg.sv
// Shared types for the fetch PC unit: EX branch-select codes, fetch
// controller states and the queue entry layout.
package riscv_pkg;

  localparam int unsigned CORE_XLEN = 32;

  typedef enum logic [1:0] {
    BR_TARGET = 2'b00,
    BR_SEQ    = 2'b01,
    BR_JALR   = 2'b10
  } branch_op_t;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [31:0]          instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs feeding IF/ID.
// Ports: push/push_pc/push_instr write side, pop read side, clear empties
// the queue (wins over push/pop), count = occupancy, head_* = oldest entry.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [31:0]     push_instr,
  input  logic            pop,
  input  logic            clear,
  output logic [1:0]      count,
  output logic [XLEN-1:0] head_pc,
  output logic [31:0]     head_instr
);

  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  fetch_entry_t in_entry;
  logic [1:0]   count_q, count_d;

  always_comb begin
    in_entry.pc    = CORE_XLEN'(push_pc);
    in_entry.instr = push_instr;
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      // Entry 0 is always the head; a pop shifts entry 1 down.
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) e0_d = in_entry;
          else                 e1_d = in_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_d = in_entry;
          end else begin
            e0_d = e1_q;
            e1_d = in_entry;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= '0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign head_pc    = XLEN'(e0_q.pc);
  assign head_instr = e0_q.instr;

  // The issue rule keeps at most one request in flight and only issues
  // below two entries, so a response always finds a free slot.
  push_never_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count_q == 2'd2));

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator and instruction-fetch controller.
// Ports: branch_op/ex_valid/branch_target/jalr_target from EX select a
// redirect; imem_req_* issue fetches (valid/ready), imem_rsp_* return words;
// if_valid/if_pc/if_instr present the queue head to decode (id_stall holds
// it); flush_if_id/flush_id_ex/misaligned pulse combinationally on redirect.
module fetch_pc_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      branch_op,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            id_stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            misaligned
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] redirect_pc;
  logic            req_fire;
  logic            push, pop;
  logic [1:0]      q_count;

  always_comb begin
    redirect    = ex_valid && (branch_op == BR_TARGET || branch_op == BR_JALR);
    target      = (branch_op == BR_JALR) ? {jalr_target[XLEN-1:1], 1'b0}
                                         : branch_target;
    redirect_pc = target[1] ? TRAP_VEC : target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // WAIT/DROP both mean one request is outstanding; FETCH means none.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d = redirect_pc;
          if (req_fire) state_d = DROP;
        end else if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = imem_rsp_valid ? FETCH : DROP;
        end else if (imem_rsp_valid) begin
          state_d = FETCH;
        end
      end
      DROP: begin
        if (redirect) pc_d = redirect_pc;
        // A response arriving alongside a redirect still retires the stale
        // request; staying in DROP would wait for a response that never comes.
        if (imem_rsp_valid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req_valid = rst_n && (state_q == FETCH) && (q_count < 2'd2);
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    push           = (state_q == WAIT) && imem_rsp_valid && !redirect;
    pop            = if_valid && !id_stall && !redirect;
    flush_if_id    = redirect;
    flush_id_ex    = redirect;
    misaligned     = redirect && target[1];
  end

  assign if_valid = (q_count != 2'd0);

  fetch_queue #(
    .XLEN(XLEN)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_pc   (req_pc_q),
    .push_instr(imem_rsp_data),
    .pop       (pop),
    .clear     (redirect),
    .count     (q_count),
    .head_pc   (if_pc),
    .head_instr(if_instr)
  );

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  branch_op;
  logic        ex_valid;
  logic [31:0] branch_target, jalr_target;
  logic        id_stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic        flush_if_id, flush_id_ex, misaligned;

  fetch_pc_unit #(
    .XLEN    (32),
    .RESET_PC(RESET_PC),
    .TRAP_VEC(TRAP_VEC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch_op     (branch_op),
    .ex_valid      (ex_valid),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .id_stall      (id_stall),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: the PC decode must see next (instruction = mem_word(pc)).
  logic [31:0] exp_q[$];
  logic [31:0] hs_log[$];

  int          mem_lat = 1;
  bit          pend = 0;
  logic [31:0] pend_addr = '0;
  int          pend_wait = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] target_of(input logic [1:0] op,
                                            input logic [31:0] bt,
                                            input logic [31:0] jt);
    logic [31:0] j;
    j = jt & 32'hFFFF_FFFE;
    return (op == 2'b10) ? j : bt;
  endfunction

  function automatic logic [31:0] new_pc_of(input logic [31:0] t);
    logic [31:0] tt;
    tt = t;
    return tt[1] ? TRAP_VEC : tt;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: drives responses on the falling edge, records handshakes later
  // in the same cycle. Pending requests survive reset to model a late reply.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (pend && pend_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend           = 1'b0;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (pend) pend_wait--;
      end
      #2;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        check("single_outstanding", 32'(pend), 32'd0);
        pend      = 1'b1;
        pend_addr = imem_req_addr;
        pend_wait = mem_lat - 1;
        hs_log.push_back(imem_req_addr);
      end
    end
  end

  // Monitor: checks every cycle against rules computed from the inputs.
  initial begin
    bit          redir, redir_prev, req_hold, if_hold;
    logic [31:0] t, redir_addr, req_addr_prev, pc_prev, instr_prev, e;
    redir_prev = 0; req_hold = 0; if_hold = 0;
    redir_addr = '0; req_addr_prev = '0; pc_prev = '0; instr_prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_flush", 32'(flush_if_id | flush_id_ex | misaligned), 32'd0);
        redir_prev = 0; req_hold = 0; if_hold = 0;
        continue;
      end
      redir = ex_valid && (branch_op == 2'b00 || branch_op == 2'b10);
      t     = target_of(branch_op, branch_target, jalr_target);
      check("flush_if_id", 32'(flush_if_id), 32'(redir));
      check("flush_id_ex", 32'(flush_id_ex), 32'(redir));
      check("misaligned", 32'(misaligned), 32'(redir && t[1]));
      if (redir_prev) check("redirect_addr", imem_req_addr, redir_addr);
      if (req_hold) begin
        check("req_valid_held", 32'(imem_req_valid), 32'd1);
        check("req_addr_held", imem_req_addr, req_addr_prev);
      end
      if (if_hold) begin
        check("stall_if_valid", 32'(if_valid), 32'd1);
        check("stall_if_pc", if_pc, pc_prev);
        check("stall_if_instr", if_instr, instr_prev);
      end
      if (if_valid && !id_stall && !redir) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got pc %h expected no instruction", if_pc);
        end else begin
          e = exp_q.pop_front();
          check("if_pc", if_pc, e);
          check("if_instr", if_instr, mem_word(e));
          exp_q.push_back(e + 32'd4);
        end
      end
      redir_prev    = redir;
      redir_addr    = new_pc_of(t);
      req_hold      = imem_req_valid && !imem_req_ready && !redir;
      req_addr_prev = imem_req_addr;
      if_hold       = if_valid && id_stall && !redir;
      pc_prev       = if_pc;
      instr_prev    = if_instr;
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
    ex_valid      = 1'b0;
    branch_op     = 2'($urandom);
    branch_target = $urandom;
    jalr_target   = $urandom;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] bt, input logic [31:0] jt);
    ex_valid      = 1'b1;
    branch_op     = op;
    branch_target = bt;
    jalr_target   = jt;
    if (op == 2'b00 || op == 2'b10) begin
      exp_q.delete();
      exp_q.push_back(new_pc_of(target_of(op, bt, jt)));
    end
  endtask

  task automatic wait_handshake(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      next_cycle();
      #2;
      if (imem_req_valid && imem_req_ready) seen = 1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    bit          seen;
    logic [31:0] bt, jt;
    rst_n = 1'b0; ex_valid = 1'b0; branch_op = '0; branch_target = '0;
    jalr_target = '0; id_stall = 1'b0; imem_req_ready = 1'b0;
    exp_q.push_back(RESET_PC);
    repeat (3) @(negedge clk);

    // 1: sequential fetch from reset with a 1-cycle memory
    next_cycle();
    rst_n = 1'b1; imem_req_ready = 1'b1; mem_lat = 1;
    repeat (12) next_cycle();
    check("t1_req_count", 32'(hs_log.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++)
      if (hs_log.size() > i) check("t1_req_addr", hs_log[i], 32'(4 * i));

    // 2: decode stall fills the queue and blocks new requests
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      id_stall = 1'b1;
    end
    #2;
    check("t2_req_valid_full", 32'(imem_req_valid), 32'd0);
    check("t2_if_valid_full", 32'(if_valid), 32'd1);
    next_cycle();
    id_stall = 1'b0;
    repeat (8) next_cycle();

    // 3: branch while a slow response is outstanding
    mem_lat = 3;
    wait_handshake("t3_handshake");
    next_cycle();
    issue(2'b00, 32'h0000_0040, $urandom);
    repeat (6) next_cycle();
    mem_lat = 1;
    repeat (6) next_cycle();

    // 4: jalr clears bit 0; bit 1 set traps; target near the top wraps
    next_cycle();
    issue(2'b10, $urandom, 32'h0000_0081);
    repeat (6) next_cycle();
    issue(2'b10, $urandom, 32'h0000_0082);
    repeat (6) next_cycle();
    issue(2'b00, 32'hFFFF_FFFC, $urandom);
    repeat (8) next_cycle();

    // 5: redirect on the same cycle as the response
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      next_cycle();
      if (imem_rsp_valid) seen = 1;
    end
    check("t5_rsp_seen", 32'(seen), 32'd1);
    issue(2'b00, 32'h0000_0200, $urandom);
    next_cycle();
    #2;
    check("t5_req_valid", 32'(imem_req_valid), 32'd1);
    check("t5_req_addr", imem_req_addr, 32'h0000_0200);
    repeat (6) next_cycle();

    // 6: reset with a request in flight; the late reply must be ignored
    mem_lat = 6;
    wait_handshake("t6_handshake");
    next_cycle();
    rst_n = 1'b0; imem_req_ready = 1'b0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      #2;
      check("t6_no_push", 32'(if_valid), 32'd0);
    end
    check("t6_late_rsp_sent", 32'(pend), 32'd0);
    base = hs_log.size();
    mem_lat = 1;
    next_cycle();
    imem_req_ready = 1'b1;
    repeat (10) next_cycle();
    check("t6_restart_seen", 32'(hs_log.size() > base), 32'd1);
    if (hs_log.size() > base) check("t6_restart_addr", hs_log[base], RESET_PC);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      next_cycle();
      id_stall       = ($urandom_range(0, 9) < 3);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      mem_lat        = $urandom_range(1, 3);
      if ($urandom_range(0, 11) == 0) begin
        bt = 32'($urandom_range(0, 4095)) & 32'hFFFF_FFFE;
        jt = 32'($urandom_range(0, 4095));
        issue(2'($urandom_range(0, 3)), bt, jt);
      end
    end
    next_cycle();
    id_stall = 1'b0; imem_req_ready = 1'b1;
    repeat (10) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
